// File: rtl/ball_motion_ctrl.sv
// Ball position/direction controller for a brick-breaker game: tracks the paddle while idle,
// steps the ball once per motion tick and reflects it off bricks, walls and the paddle.
// All outputs are registered (one clock after the inputs that cause them). There is no backpressure.
module ball_motion_ctrl #(
  parameter int COORD_W      = 8,
  parameter int X_MAX        = 159,
  parameter int Y_MAX        = 119,
  parameter int PADDLE_Y     = 110,
  parameter int PADDLE_W     = 16,
  parameter int TICK_DIV     = 1000000,
  parameter int SPD_MAX      = 3,
  parameter int HITS_PER_SPD = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               game_en,
  input  logic               launch,
  input  logic [COORD_W-1:0] paddle_x,
  input  logic               brick_hit_x,
  input  logic               brick_hit_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic [1:0]         speed,
  output logic [1:0]         state,
  output logic               ball_lost
);

  // Geometry is evaluated one bit wider than a coordinate so sums never wrap.
  localparam int EW  = COORD_W + 1;
  localparam int TCW = $clog2(TICK_DIV);
  localparam int HCW = $clog2(HITS_PER_SPD + 1);

  localparam logic [EW-1:0]  X_MAX_E     = EW'(X_MAX);
  localparam logic [EW-1:0]  Y_MAX_E     = EW'(Y_MAX);
  localparam logic [EW-1:0]  PADDLE_Y_E  = EW'(PADDLE_Y);
  localparam logic [EW-1:0]  REST_Y_E    = EW'(PADDLE_Y - 1);
  localparam logic [EW-1:0]  HALF_W_E    = EW'(PADDLE_W / 2);
  localparam logic [EW-1:0]  QUART_W_E   = EW'(PADDLE_W / 4);
  localparam logic [EW-1:0]  THREEQ_W_E  = EW'((3 * PADDLE_W) / 4);
  localparam logic [EW-1:0]  PW_M1_E     = EW'(PADDLE_W - 1);
  localparam logic [TCW-1:0] TICK_LAST   = TCW'(TICK_DIV - 1);
  localparam logic [HCW-1:0] HITS_E      = HCW'(HITS_PER_SPD);
  localparam logic [1:0]     SPD_MAX_E   = 2'(SPD_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVING = 2'd1,
    S_LOST   = 2'd2
  } state_t;

  state_t           fsm;
  logic [TCW-1:0]   tick_cnt;
  logic [HCW-1:0]   hit_cnt;
  logic             px;
  logic             py;

  assign state = fsm;

  // Resting position on top of the paddle centre, clamped to the right edge.
  logic [EW-1:0]      idle_sum;
  logic [COORD_W-1:0] idle_x;
  assign idle_sum = {1'b0, paddle_x} + HALF_W_E;
  assign idle_x   = (idle_sum > X_MAX_E) ? X_MAX_E[COORD_W-1:0] : idle_sum[COORD_W-1:0];

  logic tick;
  logic hit_any;
  logic [HCW-1:0] hit_cnt_inc;
  assign tick        = (tick_cnt == TICK_LAST);
  assign hit_any     = brick_hit_x | brick_hit_y;
  assign hit_cnt_inc = hit_cnt + HCW'(1);

  // Extended operands for the motion arithmetic.
  logic [EW-1:0] bx_e, by_e, spd_e, pad_l, pad_r, pad_q1, pad_q3;
  assign bx_e   = {1'b0, ball_x};
  assign by_e   = {1'b0, ball_y};
  assign spd_e  = {{(EW-2){1'b0}}, speed};
  assign pad_l  = {1'b0, paddle_x};
  assign pad_r  = pad_l + PW_M1_E;
  assign pad_q1 = pad_l + QUART_W_E;
  assign pad_q3 = pad_l + THREEQ_W_E;

  logic [EW-1:0] mv_x, mv_y;
  logic          mv_dx, mv_dy;
  logic          pre_dx, pre_dy;
  logic          mv_catch, mv_floor;

  // Candidate ball state for a motion tick: brick reflection first, then walls/paddle/floor.
  // A brick pulse landing on the tick cycle itself is folded into that tick's reflection.
  always_comb begin
    pre_dx   = dir_x ^ (px | brick_hit_x);
    pre_dy   = dir_y ^ (py | brick_hit_y);
    mv_x     = bx_e;
    mv_y     = by_e;
    mv_dx    = pre_dx;
    mv_dy    = pre_dy;
    mv_catch = 1'b0;
    mv_floor = 1'b0;

    // Horizontal: bounce off the left edge or the right wall, else step.
    if (pre_dx && (bx_e <= spd_e)) begin
      mv_x  = '0;
      mv_dx = 1'b0;
    end else if (!pre_dx && ((bx_e + spd_e) >= X_MAX_E)) begin
      mv_x  = X_MAX_E;
      mv_dx = 1'b1;
    end else if (pre_dx) begin
      mv_x = bx_e - spd_e;
    end else begin
      mv_x = bx_e + spd_e;
    end

    // Vertical: ceiling when rising; paddle or floor when falling.
    if (pre_dy) begin
      if (by_e <= spd_e) begin
        mv_y  = '0;
        mv_dy = 1'b0;
      end else begin
        mv_y = by_e - spd_e;
      end
    end else begin
      mv_catch = (by_e < PADDLE_Y_E) && ((by_e + spd_e) >= PADDLE_Y_E) &&
                 (bx_e >= pad_l) && (bx_e <= pad_r);
      if (mv_catch) begin
        mv_y  = REST_Y_E;
        mv_dy = 1'b1;
        // Outer quarters of the paddle steer the ball; the middle half keeps its heading.
        if (bx_e < pad_q1) begin
          mv_dx = 1'b1;
        end else if (bx_e >= pad_q3) begin
          mv_dx = 1'b0;
        end
      end else if ((by_e + spd_e) > Y_MAX_E) begin
        mv_floor = 1'b1;
      end else begin
        mv_y = by_e + spd_e;
      end
    end
  end

  // Game FSM with all ball registers, tick divider, pending brick flags and hit/speed counter.
  always_ff @(posedge clock) begin
    ball_lost <= 1'b0;
    if (reset || !game_en || (fsm != S_MOVING)) begin
      // Reset, disable, IDLE and the single LOST cycle all park the ball on the paddle.
      ball_x   <= idle_x;
      ball_y   <= REST_Y_E[COORD_W-1:0];
      dir_x    <= 1'b0;
      dir_y    <= 1'b1;
      speed    <= 2'd1;
      tick_cnt <= '0;
      hit_cnt  <= '0;
      px       <= 1'b0;
      py       <= 1'b0;
      if (!reset && game_en && (fsm == S_IDLE) && launch) begin
        fsm <= S_MOVING;
      end else begin
        fsm <= S_IDLE;
      end
    end else begin
      if (tick) begin
        tick_cnt <= '0;
        px       <= 1'b0;
        py       <= 1'b0;
        if (mv_floor) begin
          // Ball leaves through the floor: freeze where it was and flag the loss.
          fsm       <= S_LOST;
          ball_lost <= 1'b1;
        end else begin
          ball_x <= mv_x[COORD_W-1:0];
          ball_y <= mv_y[COORD_W-1:0];
          dir_x  <= mv_dx;
          dir_y  <= mv_dy;
        end
      end else begin
        tick_cnt <= tick_cnt + TCW'(1);
        if (brick_hit_x) px <= 1'b1;
        if (brick_hit_y) py <= 1'b1;
      end

      // One count per hit cycle; speed saturates and the counter then stays empty.
      if (hit_any) begin
        if (speed >= SPD_MAX_E) begin
          hit_cnt <= '0;
        end else if (hit_cnt_inc == HITS_E) begin
          speed   <= speed + 2'd1;
          hit_cnt <= '0;
        end else begin
          hit_cnt <= hit_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed scenarios plus randomized play checked
// every cycle against a velocity-based reference model of the game rules.
module tb_ball_motion_ctrl;
  localparam int TD      = 4;
  localparam int X_MAX   = 159;
  localparam int Y_MAX   = 119;
  localparam int PY      = 110;
  localparam int PW      = 16;
  localparam int SPD_MAX = 3;
  localparam int HPS     = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       game_en = 1'b0;
  logic       launch = 1'b0;
  logic [7:0] paddle_x = 8'd0;
  logic       bhx = 1'b0;
  logic       bhy = 1'b0;
  logic [7:0] ball_x, ball_y;
  logic       dir_x, dir_y;
  logic [1:0] speed, state;
  logic       ball_lost;

  ball_motion_ctrl #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .game_en(game_en), .launch(launch),
    .paddle_x(paddle_x), .brick_hit_x(bhx), .brick_hit_y(bhy),
    .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
    .speed(speed), .state(state), .ball_lost(ball_lost)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: state 0/1/2, position, heading bits, speed, counters.
  int m_st, m_bx, m_by, m_dx, m_dy, m_spd, m_lost, m_tc, m_hc, m_pfx, m_pfy;

  task automatic model_idle();
    int p;
    p = int'(paddle_x);
    m_bx = (p + PW/2 > X_MAX) ? X_MAX : p + PW/2;
    m_by = PY - 1;
    m_dx = 0; m_dy = 1; m_spd = 1;
    m_tc = 0; m_hc = 0; m_pfx = 0; m_pfy = 0; m_lost = 0;
  endtask

  task automatic model_step();
    int p, sp, dx, dy, tx, ty, nbx, nby, off, nst;
    bit fell;
    p = int'(paddle_x);
    if (reset || !game_en || m_st != 1) begin
      nst = (!reset && game_en && m_st == 0 && launch) ? 1 : 0;
      model_idle();
      m_st = nst;
    end else begin
      m_lost = 0;
      sp = m_spd;
      if (m_tc == TD - 1) begin
        dx = m_dx ^ (m_pfx | int'(bhx));
        dy = m_dy ^ (m_pfy | int'(bhy));
        tx = m_bx + (dx != 0 ? -sp : sp);
        ty = m_by + (dy != 0 ? -sp : sp);
        nbx = tx; nby = ty; fell = 0;
        if (tx <= 0) begin nbx = 0; dx = 0; end
        else if (tx >= X_MAX) begin nbx = X_MAX; dx = 1; end
        if (dy != 0) begin
          if (ty <= 0) begin nby = 0; dy = 0; end
        end else if (m_by < PY && ty >= PY && m_bx >= p && m_bx <= p + PW - 1) begin
          nby = PY - 1; dy = 1;
          off = m_bx - p;
          if (off < PW/4) dx = 1;
          else if (off >= 3*PW/4) dx = 0;
        end else if (ty > Y_MAX) begin
          fell = 1;
        end
        if (fell) begin
          m_st = 2; m_lost = 1;
        end else begin
          m_bx = nbx; m_by = nby; m_dx = dx; m_dy = dy;
        end
        m_tc = 0; m_pfx = 0; m_pfy = 0;
      end else begin
        m_tc++;
        m_pfx = m_pfx | int'(bhx);
        m_pfy = m_pfy | int'(bhy);
      end
      if (bhx || bhy) begin
        if (m_spd >= SPD_MAX) m_hc = 0;
        else begin
          m_hc++;
          if (m_hc == HPS) begin m_spd++; m_hc = 0; end
        end
      end
    end
  endtask

  task automatic cmp_all();
    chk("state", int'(state), m_st);
    chk("ball_x", int'(ball_x), m_bx);
    chk("ball_y", int'(ball_y), m_by);
    chk("dir_x", int'(dir_x), m_dx);
    chk("dir_y", int'(dir_y), m_dy);
    chk("speed", int'(speed), m_spd);
    chk("ball_lost", int'(ball_lost), m_lost);
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic drive(input logic rst, input logic en, input logic ln,
                       input logic [7:0] pad, input logic hx, input logic hy);
    reset = rst; game_en = en; launch = ln; paddle_x = pad; bhx = hx; bhy = hy;
    model_step();
    @(negedge clock);
    cmp_all();
  endtask

  initial begin
    int pulses, t, cyc;
    logic [7:0] pad;
    logic trk, rst_r, en_r, ln_r, hx_r, hy_r, ok_hit;
    m_st = 0;
    model_idle();

    // Reset state with the paddle at 40.
    drive(1, 0, 0, 8'd40, 0, 0);
    drive(1, 1, 1, 8'd40, 1, 1);
    chk("rst_state", int'(state), 0);
    chk("rst_x", int'(ball_x), 48);
    chk("rst_y", int'(ball_y), 109);
    chk("rst_speed", int'(speed), 1);
    chk("rst_dir_x", int'(dir_x), 0);
    chk("rst_dir_y", int'(dir_y), 1);
    chk("rst_lost", int'(ball_lost), 0);

    // Launch and first two motion ticks.
    drive(0, 1, 1, 8'd40, 0, 0);
    chk("launch_state", int'(state), 1);
    repeat (4) drive(0, 1, 0, 8'd40, 0, 0);
    chk("tick1_x", int'(ball_x), 49);
    chk("tick1_y", int'(ball_y), 108);
    repeat (4) drive(0, 1, 0, 8'd40, 0, 0);
    chk("tick2_x", int'(ball_x), 50);
    chk("tick2_y", int'(ball_y), 107);

    // Two vertical brick pulses within one tick window give one reflection.
    drive(0, 1, 0, 8'd40, 0, 1);
    drive(0, 1, 0, 8'd40, 0, 1);
    drive(0, 1, 0, 8'd40, 0, 0);
    drive(0, 1, 0, 8'd40, 0, 0);
    chk("brick_dir_y", int'(dir_y), 0);
    chk("brick_y", int'(ball_y), 108);
    drive(0, 1, 0, 8'd40, 1, 0);
    drive(0, 1, 0, 8'd40, 1, 0);
    chk("speed_after_4", int'(speed), 2);

    // Eight more hits: speed reaches its cap and stays there.
    pulses = 0;
    for (int i = 0; i < 64 && pulses < 8; i++) begin
      if (m_tc != TD - 1) begin
        drive(0, 1, 0, 8'd40, 1, 0);
        pulses++;
      end else begin
        drive(0, 1, 0, 8'd40, 0, 0);
      end
    end
    if (m_st == 1) chk("speed_sat", int'(speed), 3);

    // Disable mid-flight: straight back to IDLE without a loss pulse.
    drive(0, 0, 0, 8'd40, 0, 0);
    chk("drop_state", int'(state), 0);
    chk("drop_lost", int'(ball_lost), 0);

    // Launch with the paddle out of reach; the ball must fall through the floor.
    drive(0, 1, 1, 8'd40, 0, 0);
    cyc = 0;
    while (m_st != 2 && cyc < 3000) begin
      drive(0, 1, 0, 8'd200, 0, 0);
      cyc++;
    end
    if (m_st != 2) begin
      chk("lost_timeout", cyc, -1);
    end else begin
      chk("lost_state", int'(state), 2);
      chk("lost_pulse", int'(ball_lost), 1);
      drive(0, 1, 0, 8'd100, 0, 0);
      chk("relaunch_state", int'(state), 0);
      chk("relaunch_x", int'(ball_x), 108);
      chk("relaunch_y", int'(ball_y), 109);
      chk("relaunch_lost", int'(ball_lost), 0);
    end

    // Randomized play.
    pad = 8'd60;
    trk = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      if (i % 64 == 0) begin
        pad = 8'($urandom_range(0, 255));
        trk = ($urandom_range(0, 2) != 0);
      end else if (trk && $urandom_range(0, 3) == 0) begin
        t = m_bx - int'($urandom_range(0, 15));
        if (t < 0) t = 0;
        pad = t[7:0];
      end
      rst_r  = ($urandom_range(0, 799) == 0);
      en_r   = ($urandom_range(0, 399) != 0);
      ln_r   = ($urandom_range(0, 7) == 0);
      ok_hit = !(m_st == 1 && m_tc == TD - 1);
      hx_r   = ok_hit && ($urandom_range(0, 11) == 0);
      hy_r   = ok_hit && ($urandom_range(0, 11) == 0);
      drive(rst_r, en_r, ln_r, pad, hx_r, hy_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
